// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared types and codes for the multicycle RISC-V control unit.
// Holds state codes, opcodes, ALU/mux select codes and the control bundle.
package ctrl_pkg;

    typedef logic [3:0] state_t;
    typedef logic [2:0] aluFunct_t;
    typedef logic [1:0] srcB_t;
    typedef logic [1:0] memToReg_t;

    localparam state_t FETCH  = 4'd0;
    localparam state_t DECODE = 4'd1;
    localparam state_t R_EXEC = 4'd2;
    localparam state_t I_EXEC = 4'd3;
    localparam state_t ALU_WB = 4'd4;
    localparam state_t ADDR   = 4'd5;
    localparam state_t MEM_RD = 4'd6;
    localparam state_t LD_WB  = 4'd7;
    localparam state_t MEM_WR = 4'd8;
    localparam state_t LUI_WB = 4'd9;
    localparam state_t BR_INC = 4'd10;
    localparam state_t BR_CMP = 4'd11;
    localparam state_t HALT   = 4'd12;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_DWORD = 3'b011;

    localparam aluFunct_t ALU_ADD = 3'b001;
    localparam aluFunct_t ALU_SUB = 3'b010;
    localparam aluFunct_t ALU_AND = 3'b011;
    localparam aluFunct_t ALU_XOR = 3'b110;

    localparam srcB_t SRCB_REG    = 2'b00;
    localparam srcB_t SRCB_FOUR   = 2'b01;
    localparam srcB_t SRCB_IMM    = 2'b10;
    localparam srcB_t SRCB_IMM_SH = 2'b11;

    localparam memToReg_t M2R_ALU  = 2'b00;
    localparam memToReg_t M2R_MDR  = 2'b01;
    localparam memToReg_t M2R_SEXT = 2'b10;

    typedef struct packed {
        logic      PCSrc;
        aluFunct_t ALUFunct;
        logic      ALUSrcA;
        srcB_t     ALUSrcB;
        logic      PCWrite;
        logic      PCWriteCond;
        logic      BranchOp;
        logic      LoadIR;
        logic      LoadRegA;
        logic      LoadRegB;
        logic      LoadALUOut;
        logic      LoadMDR;
        logic      WriteReg;
        memToReg_t MemToReg;
        logic      DMemWrite;
        logic      Halted;
    } ctrl_t;

    // PC <- PC + 4 through the ALU result path
    function automatic ctrl_t pc4(input ctrl_t c);
        ctrl_t r;
        r          = c;
        r.ALUSrcA  = 1'b0;
        r.ALUSrcB  = SRCB_FOUR;
        r.ALUFunct = ALU_ADD;
        r.PCSrc    = 1'b0;
        r.PCWrite  = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_if.sv
// Control bus between the multicycle control unit and the datapath.
// master = control unit (reads inst, drives controls); slave = datapath.
interface unidade_controle_multiciclo_if;
    import ctrl_pkg::*;

    logic [31:0] inst;
    logic        PCSrc;
    aluFunct_t   ALUFunct;
    logic        ALUSrcA;
    srcB_t       ALUSrcB;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        BranchOp;
    logic        LoadIR;
    logic        LoadRegA;
    logic        LoadRegB;
    logic        LoadALUOut;
    logic        LoadMDR;
    logic        WriteReg;
    memToReg_t   MemToReg;
    logic        IMemWrite;
    logic        DMemWrite;
    logic        Halted;

    modport master (
        input  inst,
        output PCSrc, ALUFunct, ALUSrcA, ALUSrcB,
        output PCWrite, PCWriteCond, BranchOp,
        output LoadIR, LoadRegA, LoadRegB, LoadALUOut, LoadMDR,
        output WriteReg, MemToReg, IMemWrite, DMemWrite, Halted
    );

    modport slave (
        output inst,
        input  PCSrc, ALUFunct, ALUSrcA, ALUSrcB,
        input  PCWrite, PCWriteCond, BranchOp,
        input  LoadIR, LoadRegA, LoadRegB, LoadALUOut, LoadMDR,
        input  WriteReg, MemToReg, IMemWrite, DMemWrite, Halted
    );

endinterface

// File: rtl/unidade_controle_multiciclo_alu_control.sv
// R-type funct3/funct7 decoder: ALU operation plus illegal-encoding flag.
// In: funct3, funct7. Out: aluFunct, illegal.
module alu_control
    import ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output aluFunct_t  aluFunct,
    output logic       illegal
);

    logic [9:0] key;

    assign key = {funct7, funct3};

    always_comb begin
        aluFunct = ALU_ADD;
        illegal  = 1'b0;
        unique case (1'b1)
            (key == {7'b0000000, 3'b000}): aluFunct = ALU_ADD;
            (key == {7'b0100000, 3'b000}): aluFunct = ALU_SUB;
            (key == {7'b0000000, 3'b111}): aluFunct = ALU_AND;
            (key == {7'b0000000, 3'b100}): aluFunct = ALU_XOR;
            default:                       illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the 64-bit RISC-V datapath (add/sub/and/xor,
// addi, ld, sd, beq, bne, lui). Ports: clk, Reset (async, active-low), bus.
module unidade_controle_multiciclo
    import ctrl_pkg::*;
#(
    parameter int IMEM_WAIT = 1,
    parameter int DMEM_WAIT = 1
) (
    input logic                          clk,
    input logic                          Reset,
    unidade_controle_multiciclo_if.master bus
);

    state_t    state;
    state_t    nxt;
    state_t    decNext;
    logic [2:0] waitCnt;
    logic      lastF;
    logic      lastM;
    logic [6:0] opcode;
    logic [2:0] funct3;
    aluFunct_t aluFunct;
    logic      aluIllegal;
    ctrl_t     c;
    logic      unusedInst;

    assign opcode     = bus.inst[6:0];
    assign funct3     = bus.inst[14:12];
    assign unusedInst = ^{bus.inst[24:15], bus.inst[11:7]};

    assign lastF = (waitCnt == 3'(IMEM_WAIT));
    assign lastM = (waitCnt == 3'(DMEM_WAIT));

    alu_control uAluCtrl (
        .funct3   (funct3),
        .funct7   (bus.inst[31:25]),
        .aluFunct (aluFunct),
        .illegal  (aluIllegal)
    );

    always_comb begin
        decNext = HALT;
        unique case (1'b1)
            (opcode == OP_R):
                decNext = aluIllegal ? HALT : R_EXEC;
            (opcode == OP_IMM):
                decNext = (funct3 == 3'b000) ? I_EXEC : HALT;
            (opcode == OP_LOAD),
            (opcode == OP_STORE):
                decNext = (funct3 == F3_DWORD) ? ADDR : HALT;
            (opcode == OP_BRANCH):
                decNext = (funct3[2:1] == 2'b00) ? BR_INC : HALT;
            (opcode == OP_LUI):
                decNext = LUI_WB;
            default:
                decNext = HALT;
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            FETCH:  if (lastF) nxt = DECODE;
            DECODE: nxt = decNext;
            R_EXEC: nxt = ALU_WB;
            I_EXEC: nxt = ALU_WB;
            ALU_WB: nxt = FETCH;
            ADDR:   nxt = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD: if (lastM) nxt = LD_WB;
            LD_WB:  nxt = FETCH;
            MEM_WR: nxt = FETCH;
            LUI_WB: nxt = FETCH;
            BR_INC: nxt = BR_CMP;
            BR_CMP: nxt = FETCH;
            HALT:   nxt = HALT;
            default: nxt = HALT;
        endcase
    end

    // Counter only runs while lingering in a wait state; any exit clears it
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            state <= nxt;
            if (nxt == state && (state == FETCH || state == MEM_RD))
                waitCnt <= waitCnt + 3'd1;
            else
                waitCnt <= '0;
        end
    end

    always_comb begin
        c = '0;
        unique case (state)
            FETCH: c.LoadIR = lastF;
            DECODE: begin
                c.LoadRegA   = 1'b1;
                c.LoadRegB   = 1'b1;
                c.ALUSrcA    = 1'b0;
                c.ALUSrcB    = SRCB_IMM_SH;
                c.ALUFunct   = ALU_ADD;
                c.LoadALUOut = 1'b1;
            end
            R_EXEC: begin
                c.ALUSrcA    = 1'b1;
                c.ALUSrcB    = SRCB_REG;
                c.ALUFunct   = aluFunct;
                c.LoadALUOut = 1'b1;
            end
            I_EXEC, ADDR: begin
                c.ALUSrcA    = 1'b1;
                c.ALUSrcB    = SRCB_IMM;
                c.ALUFunct   = ALU_ADD;
                c.LoadALUOut = 1'b1;
            end
            ALU_WB: begin
                c          = pc4(c);
                c.WriteReg = 1'b1;
                c.MemToReg = M2R_ALU;
            end
            MEM_RD: c.LoadMDR = lastM;
            LD_WB: begin
                c          = pc4(c);
                c.WriteReg = 1'b1;
                c.MemToReg = M2R_MDR;
            end
            MEM_WR: begin
                c           = pc4(c);
                c.DMemWrite = 1'b1;
            end
            LUI_WB: begin
                c          = pc4(c);
                c.WriteReg = 1'b1;
                c.MemToReg = M2R_SEXT;
            end
            // ALUOut keeps the target computed in DECODE
            BR_INC: c = pc4(c);
            BR_CMP: begin
                c.ALUSrcA     = 1'b1;
                c.ALUSrcB     = SRCB_REG;
                c.ALUFunct    = ALU_SUB;
                c.PCSrc       = 1'b1;
                c.PCWriteCond = 1'b1;
                c.BranchOp    = bus.inst[12];
            end
            HALT: c.Halted = 1'b1;
            default: c = '0;
        endcase
        // Controls go quiet as soon as reset is asserted
        if (!Reset) c = '0;
    end

    assign bus.PCSrc       = c.PCSrc;
    assign bus.ALUFunct    = c.ALUFunct;
    assign bus.ALUSrcA     = c.ALUSrcA;
    assign bus.ALUSrcB     = c.ALUSrcB;
    assign bus.PCWrite     = c.PCWrite;
    assign bus.PCWriteCond = c.PCWriteCond;
    assign bus.BranchOp    = c.BranchOp;
    assign bus.LoadIR      = c.LoadIR;
    assign bus.LoadRegA    = c.LoadRegA;
    assign bus.LoadRegB    = c.LoadRegB;
    assign bus.LoadALUOut  = c.LoadALUOut;
    assign bus.LoadMDR     = c.LoadMDR;
    assign bus.WriteReg    = c.WriteReg;
    assign bus.MemToReg    = c.MemToReg;
    assign bus.IMemWrite   = 1'b0;
    assign bus.DMemWrite   = c.DMemWrite;
    assign bus.Halted      = c.Halted;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Testbench for unidade_controle_multiciclo.
// Checks every cycle against an instruction-level model plus literal pins.
module tb_unidade_controle_multiciclo;

    localparam int IW = 1;
    localparam int DW = 1;

    typedef struct packed {
        logic       PCSrc;
        logic [2:0] fn;
        logic       srcA;
        logic [1:0] srcB;
        logic       pcW;
        logic       pcWC;
        logic       brOp;
        logic       ldIR;
        logic       ldA;
        logic       ldB;
        logic       ldOut;
        logic       ldMDR;
        logic       wReg;
        logic [1:0] m2r;
        logic       iW;
        logic       dW;
        logic       halted;
    } ex_t;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] instR = 32'h0;

    always #5 clk = ~clk;

    unidade_controle_multiciclo_if ifc ();
    unidade_controle_multiciclo_if ifc3 ();

    assign ifc.inst  = instR;
    assign ifc3.inst = instR;

    unidade_controle_multiciclo #(
        .IMEM_WAIT (IW),
        .DMEM_WAIT (DW)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (ifc)
    );

    unidade_controle_multiciclo #(
        .IMEM_WAIT (1),
        .DMEM_WAIT (3)
    ) dut3 (
        .clk   (clk),
        .Reset (Reset),
        .bus   (ifc3)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic ex_t actual();
        ex_t a;
        a.PCSrc  = ifc.PCSrc;
        a.fn     = ifc.ALUFunct;
        a.srcA   = ifc.ALUSrcA;
        a.srcB   = ifc.ALUSrcB;
        a.pcW    = ifc.PCWrite;
        a.pcWC   = ifc.PCWriteCond;
        a.brOp   = ifc.BranchOp;
        a.ldIR   = ifc.LoadIR;
        a.ldA    = ifc.LoadRegA;
        a.ldB    = ifc.LoadRegB;
        a.ldOut  = ifc.LoadALUOut;
        a.ldMDR  = ifc.LoadMDR;
        a.wReg   = ifc.WriteReg;
        a.m2r    = ifc.MemToReg;
        a.iW     = ifc.IMemWrite;
        a.dW     = ifc.DMemWrite;
        a.halted = ifc.Halted;
        return a;
    endfunction

    function automatic ex_t withPc4(input ex_t e);
        ex_t r = e;
        r.srcA  = 1'b0;
        r.srcB  = 2'b01;
        r.fn    = 3'b001;
        r.PCSrc = 1'b0;
        r.pcW   = 1'b1;
        return r;
    endfunction

    // ---------------- instruction-level model ----------------
    ex_t q[$];
    bit  fetched  = 0;
    bit  haltM    = 0;
    bit  pendHalt = 0;
    int  doneCnt  = 0;

    function automatic string mnemonic(input logic [31:0] v);
        logic [6:0] op = v[6:0];
        logic [2:0] f3 = v[14:12];
        logic [6:0] f7 = v[31:25];
        if (op == 7'h33) begin
            if (f7 == 7'h00 && f3 == 3'd0) return "add";
            if (f7 == 7'h20 && f3 == 3'd0) return "sub";
            if (f7 == 7'h00 && f3 == 3'd7) return "and";
            if (f7 == 7'h00 && f3 == 3'd4) return "xor";
            return "bad";
        end
        if (op == 7'h13 && f3 == 3'd0) return "addi";
        if (op == 7'h03 && f3 == 3'd3) return "ld";
        if (op == 7'h23 && f3 == 3'd3) return "sd";
        if (op == 7'h63 && f3 == 3'd0) return "beq";
        if (op == 7'h63 && f3 == 3'd1) return "bne";
        if (op == 7'h37) return "lui";
        return "bad";
    endfunction

    task automatic buildFetch();
        ex_t e;
        for (int i = 0; i < IW; i++) q.push_back('0);
        e = '0;
        e.ldIR = 1'b1;
        q.push_back(e);
    endtask

    task automatic buildRest(input logic [31:0] v);
        ex_t e;
        string mn = mnemonic(v);
        e = '0;
        e.ldA = 1; e.ldB = 1; e.srcB = 2'b11; e.fn = 3'b001; e.ldOut = 1;
        q.push_back(e);
        if (mn == "add" || mn == "sub" || mn == "and" || mn == "xor" ||
            mn == "addi") begin
            e = '0;
            e.srcA  = 1;
            e.ldOut = 1;
            e.srcB  = (mn == "addi") ? 2'b10 : 2'b00;
            e.fn    = (mn == "sub") ? 3'b010 :
                      (mn == "and") ? 3'b011 :
                      (mn == "xor") ? 3'b110 : 3'b001;
            q.push_back(e);
            e = withPc4('0);
            e.wReg = 1;
            q.push_back(e);
        end else if (mn == "ld" || mn == "sd") begin
            e = '0;
            e.srcA = 1; e.srcB = 2'b10; e.fn = 3'b001; e.ldOut = 1;
            q.push_back(e);
            if (mn == "ld") begin
                for (int i = 0; i < DW; i++) q.push_back('0);
                e = '0;
                e.ldMDR = 1;
                q.push_back(e);
                e = withPc4('0);
                e.wReg = 1;
                e.m2r  = 2'b01;
                q.push_back(e);
            end else begin
                e = withPc4('0);
                e.dW = 1;
                q.push_back(e);
            end
        end else if (mn == "beq" || mn == "bne") begin
            q.push_back(withPc4('0));
            e = '0;
            e.srcA = 1; e.fn = 3'b010; e.PCSrc = 1; e.pcWC = 1;
            e.brOp = (mn == "bne");
            q.push_back(e);
        end else if (mn == "lui") begin
            e = withPc4('0);
            e.wReg = 1;
            e.m2r  = 2'b10;
            q.push_back(e);
        end else begin
            pendHalt = 1;
        end
    endtask

    int cyc = 0;
    int irCount = 0, irGap = 0, lastIr = 0;
    int irCount3 = 0, lastIr3 = 0;
    int gaps3[256];
    int dmwCnt = 0, dmwPc = 0;
    logic [2:0] lastFn = 3'b000;

    always @(negedge clk) begin
        ex_t e;
        ex_t hl;
        cyc++;
        if (!Reset) begin
            q.delete();
            fetched  = 0;
            haltM    = 0;
            pendHalt = 0;
            chk("reset_zero", 32'(actual()), 32'h0);
        end else begin
            if (haltM) begin
                hl = '0;
                hl.halted = 1;
                e = hl;
            end else begin
                if (q.size() == 0) begin
                    if (!fetched) begin
                        buildFetch();
                        fetched = 1;
                    end else begin
                        buildRest(instR);
                        fetched = 0;
                    end
                end
                e = q.pop_front();
                if (q.size() == 0 && !fetched) begin
                    if (pendHalt) haltM = 1;
                    else doneCnt++;
                end
            end
            chk("ctl", 32'(actual()), 32'(e));
            if (ifc.LoadIR) begin
                irCount++;
                irGap  = cyc - lastIr;
                lastIr = cyc;
            end
            if (ifc3.LoadIR) begin
                irCount3++;
                if (irCount3 < 256) gaps3[irCount3] = cyc - lastIr3;
                lastIr3 = cyc;
            end
            if (ifc.DMemWrite) begin
                dmwCnt++;
                if (ifc.PCWrite && !ifc.WriteReg) dmwPc++;
            end
            if (ifc.LoadALUOut && ifc.ALUSrcA && ifc.ALUSrcB == 2'b00)
                lastFn = ifc.ALUFunct;
        end
    end

    // ---------------- driver ----------------
    task automatic runInst(input logic [31:0] v, input int lat,
                           input string nm, output int idx);
        int n0, i0, g;
        instR = v;
        n0 = doneCnt;
        g = 0;
        while (doneCnt == n0 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk({nm, "_done"}, 32'(doneCnt != n0), 32'd1);
        i0 = irCount;
        g = 0;
        while (irCount == i0 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk({nm, "_lat"}, 32'(irGap), 32'(lat));
        idx = irCount;
    endtask

    initial begin
        int idx, ldIdx, d0, p0, ok, g;
        bit seen;
        ex_t hl;

        instR = 32'h002081B3;
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ldir", 32'(ifc.LoadIR), 32'd0);
        @(posedge clk); #1;
        Reset = 1'b1;
        @(negedge clk);
        chk("c1_ldir", 32'(ifc.LoadIR), 32'd0);
        @(negedge clk);
        chk("c2_ldir", 32'(ifc.LoadIR), 32'd1);
        @(negedge clk);
        chk("c3_dec", {29'd0, ifc.LoadRegA, ifc.LoadRegB, ifc.LoadALUOut},
            32'd7);

        runInst(32'h002081B3, 5, "add", idx);
        runInst(32'h40208133, 5, "sub", idx);
        chk("sub_fn", 32'(lastFn), 32'd2);
        runInst(32'h0020C1B3, 5, "xor", idx);
        chk("xor_fn", 32'(lastFn), 32'd6);
        runInst(32'h0020F1B3, 5, "and", idx);
        chk("and_fn", 32'(lastFn), 32'd3);
        runInst(32'h00508093, 5, "addi", idx);
        runInst(32'h000120B7, 4, "lui", idx);
        d0 = dmwCnt;
        p0 = dmwPc;
        runInst(32'h00313423, 5, "sd", idx);
        chk("sd_pulses", 32'(dmwCnt - d0), 32'd1);
        chk("sd_with_pc", 32'(dmwPc - p0), 32'd1);
        runInst(32'h00208463, 5, "beq", idx);
        runInst(32'h00209463, 5, "bne", idx);
        runInst(32'h0080B183, 7, "ld", ldIdx);
        runInst(32'h00508093, 5, "addi2", idx);
        chk("ld_wait3_lat", 32'(gaps3[ldIdx]), 32'd9);

        instR = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        hl = '0;
        hl.halted = 1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (actual() === hl) ok++;
        end
        chk("halt20", 32'(ok), 32'd20);

        #1 Reset = 1'b0;
        #1 chk("halt_rst", 32'(ifc.Halted), 32'd0);
        instR = 32'h0020E1B3;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b1;
        g = 0;
        while (!ifc.Halted && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("bad_rtype_halt", 32'(ifc.Halted), 32'd1);

        #1 Reset = 1'b0;
        instR = 32'h00313423;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ifc.DMemWrite) seen = 1;
        end
        chk("memwr_seen", 32'(seen), 32'd1);
        #1 Reset = 1'b0;
        #1 chk("memwr_abort", 32'(actual()), 32'd0);
        instR = 32'h000120B7;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b1;
        runInst(32'h000120B7, 4, "lui_restart", idx);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
